// File: rtl/clic_pkg.sv
// clic_pkg: shared types for the CLIC interrupt sink.
// Holds the sink FSM states, the level type and default level width.
package clic_pkg;

  localparam int unsigned PRIO_W = 8;

  typedef logic [PRIO_W-1:0] level_t;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } sink_state_e;

endpackage

// File: rtl/clic_level_stack.sv
// clic_level_stack: saved interrupt-level storage (mpil).
// Ports: clk_i, rst_ni, push_i/pop_i, data_i (level to save),
// top_o (current saved level), ovf_o (sticky overflow).
// CLIC_NEST_STACK_EN: LIFO of Depth levels, else single register.
module clic_level_stack #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [Width-1:0] data_i,
  output logic [Width-1:0] top_o,
  output logic             ovf_o
);

  if (Depth < 1) begin : g_bad_depth
    $error("clic_level_stack: Depth must be >= 1");
  end

`ifdef CLIC_NEST_STACK_EN
  localparam int unsigned CntW = $clog2(Depth + 1);

  // mem_q[0] is the top; slots at or above cnt_q are zero,
  // so an empty stack reads back 0 with no extra muxing.
  logic [Width-1:0] mem_q [Depth];
  logic [CntW-1:0]  cnt_q;
  logic             ovf_q;
  logic             full;
  logic             empty;

  assign full  = (cnt_q == CntW'(Depth));
  assign empty = (cnt_q == '0);
  assign top_o = mem_q[0];
  assign ovf_o = ovf_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(Depth); i++) begin
        mem_q[i] <= '0;
      end
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else if (push_i && !pop_i) begin
      // Shift up; when full the oldest falls off the end.
      for (int i = int'(Depth) - 1; i > 0; i--) begin
        mem_q[i] <= mem_q[i-1];
      end
      mem_q[0] <= data_i;
      if (full) begin
        ovf_q <= 1'b1;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end else if (pop_i && !push_i) begin
      for (int i = 0; i < int'(Depth) - 1; i++) begin
        mem_q[i] <= mem_q[i+1];
      end
      mem_q[Depth-1] <= '0;
      if (!empty) begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end
`else
  logic [Width-1:0] mpil_q;

  assign top_o = mpil_q;
  assign ovf_o = 1'b0;

  // Pop leaves mpil in place; push+pop would rewrite the
  // same value, so it is a no-op.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mpil_q <= '0;
    end else if (push_i && !pop_i) begin
      mpil_q <= data_i;
    end
  end
`endif

endmodule

// File: rtl/clic_irq_sink.sv
// clic_irq_sink: core-side receiver of the CLIC valid/id/level
// handshake; filters on mie/thresh/mil, requests a trap, tracks mil.
// Ports: irq_valid_i/irq_id_i/irq_level_i in, irq_ready_o out (comb);
// mie_i, thresh_i, debug_i filters; trap_req_o/trap_id_o/trap_level_o
// to pipeline, trap_ack_i back; mret_i, mil_we_i/mil_wdata_i;
// mil_o, mpil_o, nest_ovf_o status.
// CLIC_NEST_STACK_EN selects a nested level stack for mpil.
module clic_irq_sink
  import clic_pkg::*;
#(
  parameter  int unsigned N_SOURCE  = 256,
  parameter  int unsigned PrioWidth = PRIO_W,
  parameter  int unsigned NestDepth = 4,
  localparam int unsigned IdWidth   = $clog2(N_SOURCE)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 irq_valid_i,
  input  logic [IdWidth-1:0]   irq_id_i,
  input  logic [PrioWidth-1:0] irq_level_i,
  output logic                 irq_ready_o,
  input  logic                 mie_i,
  input  logic [PrioWidth-1:0] thresh_i,
  input  logic                 debug_i,
  output logic                 trap_req_o,
  output logic [IdWidth-1:0]   trap_id_o,
  output logic [PrioWidth-1:0] trap_level_o,
  input  logic                 trap_ack_i,
  input  logic                 mret_i,
  input  logic                 mil_we_i,
  input  logic [PrioWidth-1:0] mil_wdata_i,
  output logic [PrioWidth-1:0] mil_o,
  output logic [PrioWidth-1:0] mpil_o,
  output logic                 nest_ovf_o
);

  sink_state_e          state_q, state_d;
  logic [IdWidth-1:0]   id_q, id_d;
  logic [PrioWidth-1:0] lvl_q, lvl_d;
  logic [PrioWidth-1:0] mil_q, mil_d;
  logic [PrioWidth-1:0] mpil;
  logic                 eligible;
  logic                 withdraw;
  logic                 accept;

  assign eligible = irq_valid_i & mie_i & ~debug_i
                  & (irq_level_i > mil_q)
                  & (irq_level_i > thresh_i);

  // Latched level must still beat max(mil, thresh).
  assign withdraw = ~irq_valid_i | ~mie_i | debug_i
                  | (lvl_q <= mil_q)
                  | (lvl_q <= thresh_i);

  assign accept = (state_q == REQ) & trap_ack_i & ~withdraw;

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    lvl_d   = lvl_q;
    unique case (state_q)
      IDLE: begin
        if (eligible) begin
          state_d = REQ;
          id_d    = irq_id_i;
          lvl_d   = irq_level_i;
        end
      end
      REQ: begin
        if (withdraw || accept) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Accept beats mret beats software write.
  always_comb begin
    mil_d = mil_q;
    if (accept) begin
      mil_d = lvl_q;
    end else if (mret_i) begin
      mil_d = mpil;
    end else if (mil_we_i) begin
      mil_d = mil_wdata_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      id_q    <= '0;
      lvl_q   <= '0;
      mil_q   <= '0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      lvl_q   <= lvl_d;
      mil_q   <= mil_d;
    end
  end

  clic_level_stack #(
    .Width (PrioWidth),
    .Depth (NestDepth)
  ) u_stack (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push_i (accept),
    .pop_i  (mret_i),
    .data_i (mil_q),
    .top_o  (mpil),
    .ovf_o  (nest_ovf_o)
  );

  assign irq_ready_o  = accept;
  assign trap_req_o   = (state_q == REQ);
  assign trap_id_o    = id_q;
  assign trap_level_o = lvl_q;
  assign mil_o        = mil_q;
  assign mpil_o       = mpil;

endmodule
